// File: rtl/ofm_pkg.sv
// Shared types and defaults for the OFM writeback path.
package ofm_pkg;

   localparam int unsigned OFM_DATA_WIDTH = 8;
   localparam int unsigned OFM_PSUM_WIDTH = 2 * OFM_DATA_WIDTH;

   // Saturation bounds for the default output element width
   localparam int OFM_SAT_MAX = (1 << (OFM_DATA_WIDTH - 1)) - 1;
   localparam int OFM_SAT_MIN = -(1 << (OFM_DATA_WIDTH - 1));

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } ofm_state_e;

endpackage

// File: rtl/ofm_quant_lane.sv
// One lane of requantization: round-half-up right shift, then saturate.
// Optional build macro OFM_RELU_EN clamps negative results to zero.
module ofm_quant_lane
   import ofm_pkg::*;
#(
   parameter int unsigned PSUM_WIDTH = OFM_PSUM_WIDTH,
   parameter int unsigned DATA_WIDTH = OFM_DATA_WIDTH,
   parameter int          SAT_MAX    = OFM_SAT_MAX,
   parameter int          SAT_MIN    = OFM_SAT_MIN
) (
   input  logic signed [PSUM_WIDTH-1:0] psum,
   input  logic        [3:0]            shift,
   output logic        [DATA_WIDTH-1:0] q_c
);

   localparam int unsigned EW = PSUM_WIDTH + 1;
   localparam logic signed [EW-1:0] MAX_V = EW'(SAT_MAX);
   localparam logic signed [EW-1:0] MIN_V = EW'(SAT_MIN);

   logic signed [EW-1:0] ext;
   logic signed [EW-1:0] bias;
   logic signed [EW-1:0] rounded;
   logic signed [EW-1:0] shifted;

   // Extra headroom bit keeps the rounding add from overflowing
   always_comb begin
      ext     = {psum[PSUM_WIDTH-1], psum};
      bias    = (shift == 4'd0) ? '0 : (EW'(1) << (shift - 4'd1));
      rounded = ext + bias;
      shifted = rounded >>> shift;
      if (shifted > MAX_V) begin
         q_c = DATA_WIDTH'(SAT_MAX);
      end else if (shifted < MIN_V) begin
         q_c = DATA_WIDTH'(SAT_MIN);
      end else begin
         q_c = shifted[DATA_WIDTH-1:0];
      end
`ifdef OFM_RELU_EN
      if (q_c[DATA_WIDTH-1]) begin
         q_c = '0;
      end
`endif
   end

endmodule

// File: rtl/ofm_writeback.sv
// Drains requantized OFM rows from the PE array into the banked OFM memory
// and pulses a PE-array clear once the tile is written.
// Build option: OFM_RELU_EN (applied inside ofm_quant_lane).
module ofm_writeback
   import ofm_pkg::*;
#(
   parameter int unsigned SYSTOLIC_SIZE = 16,
   parameter int unsigned DATA_WIDTH    = OFM_DATA_WIDTH,
   parameter int unsigned PSUM_WIDTH    = OFM_PSUM_WIDTH,
   parameter int unsigned ADDR_WIDTH    = 19
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                start,
   input  logic [ADDR_WIDTH-1:0]               base_addr,
   input  logic [ADDR_WIDTH-1:0]               addr_stride,
   input  logic [$clog2(SYSTOLIC_SIZE):0]      num_rows,
   input  logic [3:0]                          shift,
   input  logic [SYSTOLIC_SIZE-1:0]            lane_en,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic [SYSTOLIC_SIZE*PSUM_WIDTH-1:0] in_data,
   output logic [SYSTOLIC_SIZE-1:0]            wr_en,
   output logic [ADDR_WIDTH-1:0]               wr_addr,
   output logic [SYSTOLIC_SIZE*DATA_WIDTH-1:0] wr_data,
   output logic                                busy,
   output logic                                done,
   output logic                                pe_clear
);

   localparam int unsigned CW = $clog2(SYSTOLIC_SIZE) + 1;

   ofm_state_e state, state_next;

   logic [CW-1:0]             num_rows_q;
   logic [CW-1:0]             row_cnt;
   logic [ADDR_WIDTH-1:0]     addr_q;
   logic [ADDR_WIDTH-1:0]     stride_q;
   logic [3:0]                shift_q;
   logic [SYSTOLIC_SIZE-1:0]  lane_en_q;
   logic                      accept;
   logic [SYSTOLIC_SIZE*DATA_WIDTH-1:0] quant_c;

   // Per-lane requantizers
   for (genvar i = 0; i < SYSTOLIC_SIZE; i++) begin : g_lane
      ofm_quant_lane #(
         .PSUM_WIDTH (PSUM_WIDTH),
         .DATA_WIDTH (DATA_WIDTH),
         .SAT_MAX    ((1 << (DATA_WIDTH - 1)) - 1),
         .SAT_MIN    (-(1 << (DATA_WIDTH - 1)))
      ) u_lane (
         .psum  (in_data[i*PSUM_WIDTH +: PSUM_WIDTH]),
         .shift (shift_q),
         .q_c   (quant_c[i*DATA_WIDTH +: DATA_WIDTH])
      );
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and beat-accept decode
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = (num_rows == '0) ? DONE : WRITE;
            end
         end
         WRITE: begin
            if (in_valid) begin
               accept = 1'b1;
               if (row_cnt == CW'(num_rows_q - CW'(1))) begin
                  state_next = DRAIN;
               end
            end
         end
         DRAIN:   state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Registered status outputs, aligned with the state they describe
   always_ff @(posedge clk) begin
      if (rst) begin
         in_ready <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         pe_clear <= 1'b0;
      end else begin
         in_ready <= (state_next == WRITE);
         busy     <= (state_next != IDLE);
         done     <= (state_next == DONE);
         pe_clear <= (state_next == DONE);
      end
   end

   // Tile configuration latch plus row and address counters
   always_ff @(posedge clk) begin
      if (rst) begin
         num_rows_q <= '0;
         row_cnt    <= '0;
         addr_q     <= '0;
         stride_q   <= '0;
         shift_q    <= '0;
         lane_en_q  <= '0;
      end else if (state == IDLE && start) begin
         num_rows_q <= num_rows;
         row_cnt    <= '0;
         addr_q     <= base_addr;
         stride_q   <= addr_stride;
         shift_q    <= shift;
         lane_en_q  <= lane_en;
      end else if (accept) begin
         row_cnt <= row_cnt + CW'(1);
         addr_q  <= addr_q + stride_q;
      end
   end

   // Write stage: one registered write per accepted beat
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_en   <= '0;
         wr_addr <= '0;
         wr_data <= '0;
      end else begin
         wr_en <= accept ? lane_en_q : '0;
         if (accept) begin
            wr_addr <= addr_q;
            wr_data <= quant_c;
         end
      end
   end

endmodule

// File: tb/tb_ofm_writeback.sv
// Directed self-checking bench for ofm_writeback (honours OFM_RELU_EN).
module tb_ofm_writeback;

   logic         clk;
   logic         rst;
   logic         start;
   logic [18:0]  base_addr;
   logic [18:0]  addr_stride;
   logic [4:0]   num_rows;
   logic [3:0]   shift;
   logic [15:0]  lane_en;
   logic         in_valid;
   logic         in_ready;
   logic [255:0] in_data;
   logic [15:0]  wr_en;
   logic [18:0]  wr_addr;
   logic [127:0] wr_data;
   logic         busy;
   logic         done;
   logic         pe_clear;

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] psum_v [16];
   logic [7:0]  exp_v  [16];

   ofm_writeback dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .base_addr   (base_addr),
      .addr_stride (addr_stride),
      .num_rows    (num_rows),
      .shift       (shift),
      .lane_en     (lane_en),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .busy        (busy),
      .done        (done),
      .pe_clear    (pe_clear)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [255:0] pack_psum();
      logic [255:0] r;
      for (int i = 0; i < 16; i++) r[i*16 +: 16] = psum_v[i];
      return r;
   endfunction

   function automatic logic [127:0] pack_exp();
      logic [127:0] r;
      for (int i = 0; i < 16; i++) begin
`ifdef OFM_RELU_EN
         r[i*8 +: 8] = exp_v[i][7] ? 8'h00 : exp_v[i];
`else
         r[i*8 +: 8] = exp_v[i];
`endif
      end
      return r;
   endfunction

   function automatic logic [255:0] rep_psum(input logic [15:0] v);
      return {16{v}};
   endfunction

   function automatic logic [127:0] rep_data(input logic [7:0] v);
      return {16{v}};
   endfunction

   task automatic do_start(input logic [18:0] b, input logic [18:0] s,
                           input logic [4:0] n, input logic [3:0] sh,
                           input logic [15:0] le);
      base_addr   = b;
      addr_stride = s;
      num_rows    = n;
      shift       = sh;
      lane_en     = le;
      start       = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      n_checks++;
      if ({in_ready, busy, done, pe_clear, wr_en, wr_addr, wr_data} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got rdy=%b busy=%b done=%b clr=%b en=%h addr=%h data=%h, expected all zero",
                  in_ready, busy, done, pe_clear, wr_en, wr_addr, wr_data);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      do_start(19'h00100, 19'h00010, 5'd4, 4'd0, 16'hFFFF);
      n_checks++;
      if ({busy, in_ready, done} !== 3'b110) begin
         n_fail++;
         $display("FAIL basic_busy_rise: got busy/rdy/done=%b%b%b expected 110", busy, in_ready, done);
      end
      for (int r = 0; r < 4; r++) begin
         in_valid = 1'b1;
         in_data  = rep_psum(16'd5);
         tick();
         n_checks++;
         if (wr_en !== 16'hFFFF || wr_addr !== 19'(32'h100 + 32'h10 * r) || wr_data !== rep_data(8'd5)) begin
            n_fail++;
            $display("FAIL basic_write%0d: got en=%h addr=%h data=%h expected en=ffff addr=%h data=05..",
                     r, wr_en, wr_addr, wr_data, 19'(32'h100 + 32'h10 * r));
         end
      end
      in_valid = 1'b0;
      n_checks++;
      if (in_ready !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_drain: got rdy=%b done=%b expected 0 0", in_ready, done);
      end
      tick();
      n_checks++;
      if ({done, pe_clear, busy} !== 3'b111 || wr_en !== 16'h0) begin
         n_fail++;
         $display("FAIL basic_done: got done/clr/busy=%b%b%b en=%h expected 111 en=0000", done, pe_clear, busy, wr_en);
      end
      tick();
      n_checks++;
      if ({done, pe_clear, busy} !== 3'b000) begin
         n_fail++;
         $display("FAIL basic_idle: got done/clr/busy=%b%b%b expected 000", done, pe_clear, busy);
      end
   endtask

   task automatic test_quant();
      // Rounding shift of 2
      for (int i = 0; i < 16; i++) begin psum_v[i] = 16'd0; exp_v[i] = 8'h00; end
      psum_v[0]  = 16'd6;      exp_v[0]  = 8'h02;
      psum_v[1]  = -16'sd6;    exp_v[1]  = 8'hFF;
      psum_v[2]  = 16'd5;      exp_v[2]  = 8'h01;
      psum_v[3]  = 16'h8000;   exp_v[3]  = 8'h80;
      psum_v[4]  = 16'h7FFF;   exp_v[4]  = 8'h7F;
      psum_v[5]  = -16'sd2;    exp_v[5]  = 8'h00;
      psum_v[6]  = -16'sd3;    exp_v[6]  = 8'hFF;
      psum_v[7]  = 16'd7;      exp_v[7]  = 8'h02;
      psum_v[8]  = 16'd10;     exp_v[8]  = 8'h03;
      psum_v[9]  = -16'sd10;   exp_v[9]  = 8'hFE;
      psum_v[10] = 16'd511;    exp_v[10] = 8'h7F;
      psum_v[11] = 16'd509;    exp_v[11] = 8'h7F;
      psum_v[12] = -16'sd514;  exp_v[12] = 8'h80;
      psum_v[13] = -16'sd515;  exp_v[13] = 8'h80;
      do_start(19'h00010, 19'h00001, 5'd1, 4'd2, 16'hFFFF);
      in_valid = 1'b1;
      in_data  = pack_psum();
      tick();
      in_valid = 1'b0;
      n_checks++;
      if (wr_en !== 16'hFFFF || wr_addr !== 19'h00010 || wr_data !== pack_exp()) begin
         n_fail++;
         $display("FAIL quant_shift2: got en=%h addr=%h data=%h expected en=ffff addr=00010 data=%h",
                  wr_en, wr_addr, wr_data, pack_exp());
      end
      tick();
      tick();
      // Saturation with no shift
      for (int i = 0; i < 16; i++) begin psum_v[i] = 16'd0; exp_v[i] = 8'h00; end
      psum_v[0] = 16'd300;     exp_v[0] = 8'h7F;
      psum_v[1] = -16'sd300;   exp_v[1] = 8'h80;
      psum_v[2] = -16'sd5;     exp_v[2] = 8'hFB;
      psum_v[3] = 16'd127;     exp_v[3] = 8'h7F;
      psum_v[4] = -16'sd128;   exp_v[4] = 8'h80;
      psum_v[5] = 16'd128;     exp_v[5] = 8'h7F;
      psum_v[6] = -16'sd129;   exp_v[6] = 8'h80;
      psum_v[7] = 16'd5;       exp_v[7] = 8'h05;
      do_start(19'h00020, 19'h00001, 5'd1, 4'd0, 16'hFFFF);
      in_valid = 1'b1;
      in_data  = pack_psum();
      tick();
      in_valid = 1'b0;
      n_checks++;
      if (wr_en !== 16'hFFFF || wr_data !== pack_exp()) begin
         n_fail++;
         $display("FAIL quant_sat: got en=%h data=%h expected en=ffff data=%h", wr_en, wr_data, pack_exp());
      end
      tick();
      tick();
   endtask

   task automatic test_lane_mask();
      do_start(19'h00040, 19'h00001, 5'd1, 4'd0, 16'h00FF);
      in_valid = 1'b1;
      in_data  = rep_psum(16'd9);
      tick();
      in_valid = 1'b0;
      n_checks++;
      if (wr_en !== 16'h00FF || wr_data !== rep_data(8'd9)) begin
         n_fail++;
         $display("FAIL lane_mask: got en=%h data=%h expected en=00ff data=09..", wr_en, wr_data);
      end
      tick();
      tick();
   endtask

   task automatic test_gaps();
      logic [4:0] pattern;
      int row;
      int writes;
      pattern = 5'b10101;
      row     = 0;
      writes  = 0;
      do_start(19'h00200, 19'h00020, 5'd3, 4'd0, 16'hFFFF);
      for (int c = 0; c < 5; c++) begin
         in_valid = pattern[c];
         in_data  = rep_psum(16'(row + 1));
         tick();
         n_checks++;
         if (pattern[c]) begin
            writes++;
            if (wr_en !== 16'hFFFF || wr_addr !== 19'(32'h200 + 32'h20 * row) || wr_data !== rep_data(8'(row + 1))) begin
               n_fail++;
               $display("FAIL gaps_write%0d: got en=%h addr=%h data=%h expected en=ffff addr=%h",
                        row, wr_en, wr_addr, wr_data, 19'(32'h200 + 32'h20 * row));
            end
            row++;
         end else if (wr_en !== 16'h0) begin
            n_fail++;
            $display("FAIL gaps_idle_cycle%0d: got en=%h expected 0000", c, wr_en);
         end
      end
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      n_checks++;
      if (done !== 1'b1 || wr_en !== 16'h0 || writes != 3) begin
         n_fail++;
         $display("FAIL gaps_done: got done=%b en=%h writes=%0d expected 1 0000 3", done, wr_en, writes);
      end
      tick();
   endtask

   task automatic test_wrap();
      do_start(19'h7FFF0, 19'h00010, 5'd2, 4'd0, 16'hFFFF);
      in_valid = 1'b1;
      in_data  = rep_psum(16'd1);
      tick();
      n_checks++;
      if (wr_addr !== 19'h7FFF0 || wr_en !== 16'hFFFF) begin
         n_fail++;
         $display("FAIL wrap_row0: got addr=%h en=%h expected 7fff0 ffff", wr_addr, wr_en);
      end
      tick();
      in_valid = 1'b0;
      n_checks++;
      if (wr_addr !== 19'h00000 || wr_en !== 16'hFFFF) begin
         n_fail++;
         $display("FAIL wrap_row1: got addr=%h en=%h expected 00000 ffff", wr_addr, wr_en);
      end
      tick();
      tick();
   endtask

   task automatic test_zero_rows();
      in_valid = 1'b1;
      do_start(19'h00300, 19'h00001, 5'd0, 4'd0, 16'hFFFF);
      n_checks++;
      if ({busy, done, pe_clear, in_ready} !== 4'b1110 || wr_en !== 16'h0) begin
         n_fail++;
         $display("FAIL zero_rows_done: got busy/done/clr/rdy=%b%b%b%b en=%h expected 1110 0000",
                  busy, done, pe_clear, in_ready, wr_en);
      end
      tick();
      in_valid = 1'b0;
      n_checks++;
      if ({busy, done, wr_en} !== 18'h0) begin
         n_fail++;
         $display("FAIL zero_rows_idle: got busy=%b done=%b en=%h expected 0 0 0000", busy, done, wr_en);
      end
   endtask

   task automatic test_start_ignored();
      do_start(19'h00040, 19'h00001, 5'd2, 4'd0, 16'hFFFF);
      in_valid = 1'b1;
      in_data  = rep_psum(16'd3);
      tick();
      base_addr = 19'h00300;
      num_rows  = 5'd8;
      start     = 1'b1;
      tick();
      start    = 1'b0;
      in_valid = 1'b0;
      n_checks++;
      if (wr_addr !== 19'h00041 || wr_en !== 16'hFFFF || in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL start_ignored_write: got addr=%h en=%h rdy=%b expected 00041 ffff 0", wr_addr, wr_en, in_ready);
      end
      tick();
      n_checks++;
      if (done !== 1'b1) begin
         n_fail++;
         $display("FAIL start_ignored_done: got done=%b expected 1", done);
      end
      tick();
   endtask

   task automatic test_mid_reset();
      int extra;
      extra = 0;
      do_start(19'h00500, 19'h00001, 5'd8, 4'd0, 16'hFFFF);
      in_valid = 1'b1;
      in_data  = rep_psum(16'd2);
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++;
      if ({in_ready, busy, done, pe_clear, wr_en, wr_addr, wr_data} !== '0) begin
         n_fail++;
         $display("FAIL mid_reset_outputs: got rdy=%b busy=%b done=%b clr=%b en=%h addr=%h data=%h expected all zero",
                  in_ready, busy, done, pe_clear, wr_en, wr_addr, wr_data);
      end
      for (int c = 0; c < 8; c++) begin
         tick();
         if (wr_en !== 16'h0 || done !== 1'b0 || pe_clear !== 1'b0) extra++;
      end
      in_valid = 1'b0;
      n_checks++;
      if (extra != 0) begin
         n_fail++;
         $display("FAIL mid_reset_quiet: got %0d active cycles expected 0", extra);
      end
   endtask

   initial begin
      rst         = 1'b1;
      start       = 1'b0;
      base_addr   = '0;
      addr_stride = '0;
      num_rows    = '0;
      shift       = '0;
      lane_en     = '0;
      in_valid    = 1'b0;
      in_data     = '0;
      test_reset();
      test_basic();
      test_quant();
      test_lane_mask();
      test_gaps();
      test_wrap();
      test_zero_rows();
      test_start_ignored();
      test_mid_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
